axi_lite_irq_ctrl: RTL and testbench

//  AXI4-Lite slave interrupt controller on one crossbar slave port.

---
 rtl/irqc_pkg.sv | 39 +++
 rtl/axi_lite_irq_ctrl_if.sv | 35 +++
 rtl/irqc_sync.sv | 23 ++
 rtl/axi_lite_irq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_axi_lite_irq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irqc_pkg.sv
// rtl/irqc_pkg.sv - shared register map, FSM state types and response codes for the interrupt controller
package irqc_pkg;

  localparam logic [31:0] IRQC_PENDING  = 32'h00;
  localparam logic [31:0] IRQC_ENABLE   = 32'h04;
  localparam logic [31:0] IRQC_STATUS   = 32'h08;
  localparam logic [31:0] IRQC_EDGE_SEL = 32'h0C;
  localparam logic [31:0] IRQC_ID       = 32'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  typedef enum logic [2:0] {
    SEL_PENDING,
    SEL_ENABLE,
    SEL_STATUS,
    SEL_EDGE_SEL,
    SEL_ID,
    SEL_NONE
  } reg_sel_e;

  // Byte-lane bits [1:0] are masked off so any alignment within a word hits the register.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    logic [31:0] word;
    word = addr & 32'hFFFF_FFFC;
    case (word)
      IRQC_PENDING:  return SEL_PENDING;
      IRQC_ENABLE:   return SEL_ENABLE;
      IRQC_STATUS:   return SEL_STATUS;
      IRQC_EDGE_SEL: return SEL_EDGE_SEL;
      IRQC_ID:       return SEL_ID;
      default:       return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/axi_lite_irq_ctrl_if.sv
// rtl/axi_lite_irq_ctrl_if.sv - AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views
interface axi_lite_irq_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/irqc_sync.sv
// rtl/irqc_sync.sv - two-flop synchronizer bringing asynchronous interrupt lines into the core clock
module irqc_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] irq_async,
  output logic [WIDTH-1:0] irq_sync
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta     <= '0;
      irq_sync <= '0;
    end else begin
      meta     <= irq_async;
      irq_sync <= meta;
    end
  end

endmodule

// File: rtl/axi_lite_irq_ctrl.sv
// rtl/axi_lite_irq_ctrl.sv - AXI4-Lite interrupt controller: pending/enable/edge-select registers,
// priority-encoded ID and one registered combined interrupt to the core.
module axi_lite_irq_ctrl
  import irqc_pkg::*;
#(
  parameter int NUM_IRQ    = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  axi_lite_irq_ctrl_if.slave  slave,
  input  logic [NUM_IRQ-1:0]  irq_i,
  output logic                irq_o
);

  localparam logic [DATA_WIDTH-1:0] IRQ_MASK = DATA_WIDTH'((64'd1 << NUM_IRQ) - 64'd1);

  logic [NUM_IRQ-1:0]      irq_s;
  logic [DATA_WIDTH-1:0]   irq_s_w, irq_prev, rise;
  logic [DATA_WIDTH-1:0]   pending, enable, edge_sel, status;
  logic [DATA_WIDTH-1:0]   pending_next, w1c;
  logic [5:0]              irq_id;

  w_state_e                w_state;
  r_state_e                r_state;
  logic                    aw_held, w_held;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    aw_fire, w_fire, ar_fire, wr_en, wr_err, rd_err;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data, wr_mask, rd_value;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  reg_sel_e                wr_sel, rd_sel;

  irqc_sync #(.WIDTH(NUM_IRQ)) u_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .irq_async (irq_i),
    .irq_sync  (irq_s)
  );

  assign irq_s_w = DATA_WIDTH'(irq_s);
  assign rise    = irq_s_w & ~irq_prev;
  assign status  = pending & enable;

  always_comb begin
    irq_id = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (status[i]) irq_id = 6'(i + 1);
    end
  end

  // Whichever of AW/W arrived earlier comes from its holding register, the other straight off the bus.
  assign aw_fire = slave.awvalid && slave.awready;
  assign w_fire  = slave.wvalid && slave.wready;
  assign ar_fire = slave.arvalid && slave.arready;
  assign wr_addr = aw_held ? aw_addr_q : slave.awaddr;
  assign wr_data = w_held ? wdata_q : slave.wdata;
  assign wr_strb = w_held ? wstrb_q : slave.wstrb;
  assign wr_en   = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
  assign wr_sel  = decode_addr(32'(wr_addr));
  assign wr_err  = (wr_sel == SEL_STATUS) || (wr_sel == SEL_ID) || (wr_sel == SEL_NONE);
  assign rd_sel  = decode_addr(32'(slave.araddr));
  assign rd_err  = (rd_sel == SEL_NONE);

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
    end
  end

  // A fresh rising edge beats a simultaneous W1C; level-mode bits simply mirror the synced line.
  assign w1c          = (wr_en && wr_sel == SEL_PENDING) ? (wr_data & wr_mask) : '0;
  assign pending_next = ((edge_sel & ((pending & ~w1c) | rise)) | (~edge_sel & irq_s_w)) & IRQ_MASK;

  always_comb begin
    case (rd_sel)
      SEL_PENDING:  rd_value = pending;
      SEL_ENABLE:   rd_value = enable;
      SEL_STATUS:   rd_value = status;
      SEL_EDGE_SEL: rd_value = edge_sel;
      SEL_ID:       rd_value = DATA_WIDTH'(irq_id);
      default:      rd_value = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_prev <= '0;
      pending  <= '0;
      enable   <= '0;
      edge_sel <= '0;
      irq_o    <= 1'b0;
    end else begin
      irq_prev <= irq_s_w;
      pending  <= pending_next;
      irq_o    <= |status;
      if (wr_en && wr_sel == SEL_ENABLE)
        enable <= ((enable & ~wr_mask) | (wr_data & wr_mask)) & IRQ_MASK;
      if (wr_en && wr_sel == SEL_EDGE_SEL)
        edge_sel <= ((edge_sel & ~wr_mask) | (wr_data & wr_mask)) & IRQ_MASK;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state       <= W_IDLE;
      slave.awready <= 1'b0;
      slave.wready  <= 1'b0;
      slave.bvalid  <= 1'b0;
      slave.bresp   <= RESP_OKAY;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_q     <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_addr_q <= slave.awaddr;
            aw_held   <= 1'b1;
          end
          if (w_fire) begin
            wdata_q <= slave.wdata;
            wstrb_q <= slave.wstrb;
            w_held  <= 1'b1;
          end
          if (wr_en) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            slave.awready <= 1'b0;
            slave.wready  <= 1'b0;
            slave.bvalid  <= 1'b1;
            slave.bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            w_state       <= W_RESP;
          end else begin
            slave.awready <= !(aw_held || aw_fire);
            slave.wready  <= !(w_held || w_fire);
          end
        end
        W_RESP: begin
          if (slave.bready) begin
            slave.bvalid  <= 1'b0;
            slave.awready <= 1'b1;
            slave.wready  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= R_IDLE;
      slave.arready <= 1'b0;
      slave.rvalid  <= 1'b0;
      slave.rresp   <= RESP_OKAY;
      slave.rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            slave.rdata   <= rd_value;
            slave.rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            slave.rvalid  <= 1'b1;
            slave.arready <= 1'b0;
            r_state       <= R_DATA;
          end else begin
            slave.arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (slave.rready) begin
            slave.rvalid  <= 1'b0;
            slave.arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_irq_ctrl.sv
// tb/tb_axi_lite_irq_ctrl.sv - directed self-checking bench for axi_lite_irq_ctrl
module tb_axi_lite_irq_ctrl;
  import irqc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq = 8'h00;
  logic       irq_o;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  axi_lite_irq_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_irq_ctrl #(.NUM_IRQ(8), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .slave (bus),
    .irq_i (irq),
    .irq_o (irq_o)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    irq = 8'h00;
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0; bus.arvalid = 0; bus.rready = 0;
    bus.awaddr = '0; bus.wdata = '0; bus.wstrb = '0; bus.araddr = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp);
    bit got = 0;
    resp = 2'bxx;
    bus.bready = 1;
    for (int c = 0; c < 20 && !got; c++) begin
      if (bus.bvalid) begin
        resp = bus.bresp;
        got = 1;
      end
      tick(1);
    end
    bus.bready = 0;
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL b_timeout: bvalid never seen, required within 20 cycles");
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1; bus.wvalid = 1;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick(1);
      if (aw_hs) begin bus.awvalid = 0; aw_done = 1; end
      if (w_hs)  begin bus.wvalid = 0;  w_done = 1;  end
    end
    bus.awvalid = 0; bus.wvalid = 0;
    if (!(aw_done && w_done)) begin
      vectors++; miscompares++;
      $display("FAIL aw_w_timeout: addr %h not accepted, required within 20 cycles", addr);
      resp = 2'bxx;
    end else begin
      wait_b(resp);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_done = 0, got = 0, ar_hs;
    data = 'x; resp = 2'bxx;
    bus.araddr = addr; bus.arvalid = 1;
    for (int c = 0; c < 20 && !ar_done; c++) begin
      ar_hs = bus.arready;
      tick(1);
      if (ar_hs) ar_done = 1;
    end
    bus.arvalid = 0;
    bus.rready = 1;
    for (int c = 0; c < 20 && ar_done && !got; c++) begin
      if (bus.rvalid) begin
        data = bus.rdata; resp = bus.rresp; got = 1;
      end
      tick(1);
    end
    bus.rready = 0;
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL read_timeout: addr %h got no R beat, required within 20 cycles", addr);
    end
  endtask

  task automatic test_reset();
    logic [31:0] offs [5] = '{IRQC_PENDING, IRQC_ENABLE, IRQC_STATUS, IRQC_EDGE_SEL, IRQC_ID};
    logic [31:0] d;
    logic [1:0]  r;
    do_reset();
    vectors++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, irq_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 000000",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, irq_o});
    end
    tick(1);
    vectors++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_idle_ready: got %b required 111", {bus.awready, bus.wready, bus.arready});
    end
    for (int i = 0; i < 5; i++) begin
      axi_read(offs[i], d, r);
      vectors++;
      if ({r, d} !== {RESP_OKAY, 32'h0}) begin
        miscompares++;
        $display("FAIL reset_read_%0h: got resp %b data %h required resp 00 data 0", offs[i], r, d);
      end
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    logic [1:0]  r;
    do_reset(); tick(1);
    axi_write(IRQC_ENABLE, 32'h01, 4'hF, r);
    axi_write(IRQC_EDGE_SEL, 32'h01, 4'hF, r);
    irq[0] = 1; tick(1);
    irq[0] = 0; tick(2);
    vectors++;
    if (irq_o !== 1'b0) begin
      miscompares++; $display("FAIL edge_irq_early: irq_o %b required 0 three cycles after pulse", irq_o);
    end
    tick(1);
    vectors++;
    if (irq_o !== 1'b1) begin
      miscompares++; $display("FAIL edge_irq_latency: irq_o %b required 1 four cycles after pulse", irq_o);
    end
    axi_read(IRQC_PENDING, d, r);
    vectors++;
    if (d !== 32'h01) begin miscompares++; $display("FAIL edge_pending: got %h required 00000001", d); end
    axi_read(IRQC_ID, d, r);
    vectors++;
    if (d !== 32'h01) begin miscompares++; $display("FAIL edge_id: got %h required 00000001", d); end
    axi_write(IRQC_PENDING, 32'h01, 4'hF, r);
    tick(1);
    vectors++;
    if (irq_o !== 1'b0) begin miscompares++; $display("FAIL w1c_irq_o: irq_o %b required 0", irq_o); end
    axi_read(IRQC_PENDING, d, r);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL w1c_pending: got %h required 00000000", d); end
  endtask

  task automatic test_set_beats_w1c();
    logic [31:0] d;
    logic [1:0]  r;
    do_reset(); tick(1);
    axi_write(IRQC_EDGE_SEL, 32'h08, 4'hF, r);
    irq[3] = 1; tick(2);
    vectors++;
    if ({bus.awready, bus.wready} !== 2'b11) begin
      miscompares++; $display("FAIL collide_ready: got %b required 11", {bus.awready, bus.wready});
    end
    bus.awaddr = IRQC_PENDING; bus.wdata = 32'h08; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    tick(1);
    bus.awvalid = 0; bus.wvalid = 0;
    wait_b(r);
    axi_read(IRQC_PENDING, d, r);
    vectors++;
    if (d !== 32'h08) begin miscompares++; $display("FAIL set_wins: got %h required 00000008", d); end
    axi_write(IRQC_PENDING, 32'h08, 4'hF, r);
    axi_read(IRQC_PENDING, d, r);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL edge_w1c_later: got %h required 00000000", d); end
  endtask

  task automatic test_level_mode();
    logic [31:0] d;
    logic [1:0]  r;
    do_reset(); tick(1);
    axi_write(IRQC_ENABLE, 32'h04, 4'hF, r);
    irq[2] = 1; tick(4);
    vectors++;
    if (irq_o !== 1'b1) begin miscompares++; $display("FAIL level_irq_o: irq_o %b required 1", irq_o); end
    axi_write(IRQC_PENDING, 32'h04, 4'hF, r);
    axi_read(IRQC_PENDING, d, r);
    vectors++;
    if (d !== 32'h04) begin miscompares++; $display("FAIL level_w1c_ignored: got %h required 00000004", d); end
    irq[2] = 0; tick(4);
    axi_read(IRQC_PENDING, d, r);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL level_drop: got %h required 00000000", d); end
  endtask

  task automatic test_priority_and_errors();
    logic [31:0] d;
    logic [1:0]  r;
    do_reset(); tick(1);
    axi_write(IRQC_EDGE_SEL, 32'hFF, 4'hF, r);
    axi_write(IRQC_ENABLE, 32'hFFFF_FFFF, 4'hF, r);
    axi_read(IRQC_ENABLE, d, r);
    vectors++;
    if (d !== 32'hFF) begin miscompares++; $display("FAIL upper_bits: got %h required 000000ff", d); end
    irq = 8'h28; tick(1);
    irq = 8'h00; tick(4);
    axi_read(IRQC_ID, d, r);
    vectors++;
    if (d !== 32'd4) begin miscompares++; $display("FAIL id_0x28: got %h required 00000004", d); end
    axi_write(IRQC_PENDING, 32'h08, 4'hF, r);
    axi_read(IRQC_ID, d, r);
    vectors++;
    if (d !== 32'd6) begin miscompares++; $display("FAIL id_after_w1c: got %h required 00000006", d); end
    axi_read(32'h14, d, r);
    vectors++;
    if ({r, d} !== {RESP_SLVERR, 32'h0}) begin
      miscompares++; $display("FAIL unmapped_read: got resp %b data %h required resp 10 data 0", r, d);
    end
    axi_write(IRQC_STATUS, 32'hFF, 4'hF, r);
    vectors++;
    if (r !== RESP_SLVERR) begin miscompares++; $display("FAIL ro_write_resp: got %b required 10", r); end
    axi_read(IRQC_STATUS, d, r);
    vectors++;
    if (d !== 32'h20) begin miscompares++; $display("FAIL ro_write_nochange: got %h required 00000020", d); end
    axi_write(IRQC_ENABLE, 32'h0000_0033, 4'b0010, r);
    axi_write(IRQC_ENABLE, 32'h0000_1133, 4'b0001, r);
    axi_read(IRQC_ENABLE, d, r);
    vectors++;
    if (d !== 32'h33) begin miscompares++; $display("FAIL wstrb_lanes: got %h required 00000033", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [1:0]  r;
    bit          hold_ok = 1;
    do_reset(); tick(1);
    bus.wdata = 32'h5A; bus.wstrb = 4'hF; bus.wvalid = 1;
    tick(1);
    bus.wvalid = 0;
    tick(2);
    vectors++;
    if ({bus.wready, bus.awready, bus.bvalid} !== 3'b010) begin
      miscompares++;
      $display("FAIL w_held: wready/awready/bvalid %b required 010", {bus.wready, bus.awready, bus.bvalid});
    end
    bus.awaddr = IRQC_ENABLE; bus.awvalid = 1;
    tick(1);
    bus.awvalid = 0;
    for (int c = 0; c < 5; c++) begin
      if ({bus.bvalid, bus.awready, bus.wready} !== 3'b100) hold_ok = 0;
      tick(1);
    end
    vectors++;
    if (!hold_ok) begin miscompares++; $display("FAIL bvalid_hold: got bvalid dropped or ready raised, required bvalid=1 ready=0"); end
    wait_b(r);
    vectors++;
    if (r !== RESP_OKAY) begin miscompares++; $display("FAIL late_aw_resp: got %b required 00", r); end
    axi_read(IRQC_ENABLE, d, r);
    vectors++;
    if (d !== 32'h5A) begin miscompares++; $display("FAIL late_aw_data: got %h required 0000005a", d); end
    bus.araddr = IRQC_ENABLE; bus.arvalid = 1;
    tick(1);
    bus.arvalid = 0;
    vectors++;
    if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h5A}) begin
      miscompares++; $display("FAIL r_data_beat: rvalid %b rdata %h required 1 0000005a", bus.rvalid, bus.rdata);
    end
    rst = 1; #2;
    vectors++;
    if (bus.rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_read: rvalid %b required 0", bus.rvalid); end
    tick(1);
    rst = 0;
    axi_read(IRQC_ENABLE, d, r);
    vectors++;
    if ({d, irq_o} !== {32'h0, 1'b0}) begin
      miscompares++; $display("FAIL rst_clears: enable %h irq_o %b required 0 0", d, irq_o);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_edge_irq();
    test_set_beats_w1c();
    test_level_mode();
    test_priority_and_errors();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
